// File: rtl/vector_add_fold_ctrl_if.sv
// Operand/result bundle for vector_add_fold_ctrl: start pulse with packed A/B vectors in,
// packed sum vector S with completion pulses and status flags out.
interface vector_add_fold_ctrl_if #(
    parameter int unsigned IN_WIDTH = 10,
    parameter int unsigned VEC_LEN  = 11
);
    logic                               enable;
    logic                               inReady;
    logic [VEC_LEN*IN_WIDTH-1:0]        A;
    logic [VEC_LEN*IN_WIDTH-1:0]        B;
    logic                               outReady;
    logic                               earlyOutReady;
    logic [VEC_LEN*(IN_WIDTH+1)-1:0]    S;
    logic                               busy;
    logic                               overrun;

    modport master (
        output enable,
        output inReady,
        output A,
        output B,
        input  outReady,
        input  earlyOutReady,
        input  S,
        input  busy,
        input  overrun
    );

    modport slave (
        input  enable,
        input  inReady,
        input  A,
        input  B,
        output outReady,
        output earlyOutReady,
        output S,
        output busy,
        output overrun
    );
endinterface

// File: rtl/vector_add_fold_ctrl.sv
// Folds a VEC_LEN-element signed vector add onto LANES shared adders, one chunk of
// LANES elements per enabled cycle, and pulses outReady when the full sum is assembled.
module vector_add_fold_ctrl #(
    parameter int unsigned IN_WIDTH = 10,
    parameter int unsigned VEC_LEN  = 11,
    parameter int unsigned LANES    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    vector_add_fold_ctrl_if.slave bus
);

    localparam int unsigned NCHUNK = (VEC_LEN + LANES - 1) / LANES;
    localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned NSLOT  = 2 ** KW;
    localparam int unsigned OW     = IN_WIDTH + 1;

    typedef logic [KW-1:0] k_t;
    localparam k_t KLast = k_t'(NCHUNK - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDone
    } state_t;

    state_t state_q, state_d;
    k_t     k_q, k_d;
    logic   overrun_q, overrun_d;
    logic   latch;

    logic [VEC_LEN-1:0][IN_WIDTH-1:0] a_q, b_q;
    logic [VEC_LEN-1:0][OW-1:0]       s_q, s_d;

    // Per-lane operand candidates, one slot per chunk index; unused slots read as zero.
    logic [IN_WIDTH-1:0] cand_a [LANES][NSLOT];
    logic [IN_WIDTH-1:0] cand_b [LANES][NSLOT];
    logic [IN_WIDTH-1:0] lane_a [LANES];
    logic [IN_WIDTH-1:0] lane_b [LANES];
    logic [OW-1:0]       lane_sum [LANES];

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        overrun_d = overrun_q;
        latch     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.inReady) begin
                    latch   = 1'b1;
                    k_d     = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // A start request while issuing is dropped, only flagged.
                if (bus.inReady) begin
                    overrun_d = 1'b1;
                end
                if (k_q == KLast) begin
                    state_d = StDone;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.inReady) begin
                    latch   = 1'b1;
                    k_d     = '0;
                    state_d = StIssue;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar c = 0; c < NSLOT; c++) begin : g_slot
            if (c * LANES + l < VEC_LEN) begin : g_used
                assign cand_a[l][c] = a_q[c*LANES+l];
                assign cand_b[l][c] = b_q[c*LANES+l];
            end else begin : g_unused
                assign cand_a[l][c] = '0;
                assign cand_b[l][c] = '0;
            end
        end
        assign lane_a[l]   = cand_a[l][k_q];
        assign lane_b[l]   = cand_b[l][k_q];
        assign lane_sum[l] = {lane_a[l][IN_WIDTH-1], lane_a[l]}
                           + {lane_b[l][IN_WIDTH-1], lane_b[l]};
    end

    // Element j is owned by lane j%LANES and written only in chunk j/LANES.
    for (genvar j = 0; j < VEC_LEN; j++) begin : g_elem
        localparam int unsigned Lane  = j % LANES;
        localparam int unsigned Chunk = j / LANES;
        assign s_d[j] = (state_q == StIssue && k_q == k_t'(Chunk)) ? lane_sum[Lane] : s_q[j];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            k_q       <= '0;
            overrun_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
        end else if (bus.enable) begin
            state_q   <= state_d;
            k_q       <= k_d;
            overrun_q <= overrun_d;
            s_q       <= s_d;
            if (latch) begin
                a_q <= bus.A;
                b_q <= bus.B;
            end
        end
    end

    // Pulses are decoded from held state, so a stall freezes them too.
    assign bus.outReady      = (state_q == StDone);
    assign bus.earlyOutReady = (state_q == StIssue) && (k_q == KLast);
    assign bus.busy          = (state_q == StIssue);
    assign bus.overrun       = overrun_q;
    assign bus.S             = s_q;

endmodule
